ysyx_22050854_wb_unit: RTL and testbench
========================================

# ysyx_22050854_wb_unit

Writeback unit for the ysyx_22050854 core. It is the write-side counterpart of the operand source generator, which only reads the register file. The unit arbitrates between ALU results and load-unit results, extracts and extends load data, and drives the register-file write port one cycle after each accepted result. It also keeps a pending-load scoreboard for hazard checks and a retired-instruction counter.

## Interface
Parameters
- XLEN, 64, datapath width; only 64 is supported.

Ports
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  64  ALU result.
- ld_issue  in  1  a load was issued this cycle; mark its rd pending.
- ld_issue_rd  in  5  destination register of the issued load.
- ld_valid  in  1  load data valid.
- ld_ready  out  1  load data accepted this cycle.
- ld_rd  in  5  load destination register.
- ld_funct3  in  3  load type: lb/lh/lw/ld/lbu/lhu/lwu = 000/001/010/011/100/101/110.
- ld_offset  in  3  address bits [2:0] of the load.
- ld_rdata  in  64  aligned 64-bit doubleword returned by memory.
- rs1, rs2  in  5  source registers queried by decode.
- rs1_busy, rs2_busy  out  1  queried register has a pending load.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  64  register-file write data.
- instret  out  64  count of retired results.

## Operation
- Arbitration: the load path has fixed priority.
  - ld_ready = 1 at all times.
  - alu_ready = !ld_valid.
  - A handshake is valid&&ready on either port; at most one handshake occurs per cycle.
- Load extraction: byte = ld_rdata >> (8*ld_offset).
  - lb: sign-extend byte[7:0]. lbu: zero-extend byte[7:0].
  - lh/lhu: use lane ld_offset[2:1] with ld_offset[0] ignored; sign- or zero-extend 16 bits.
  - lw/lwu: use lane ld_offset[2] with ld_offset[1:0] ignored; sign- or zero-extend 32 bits.
  - ld: ld_offset ignored; the full 64-bit word is used.
  - funct3 = 111: data forced to 0.
- Output stage register. On a handshake, load:
  - rf_waddr = rd;
  - rf_wdata = extracted load data or alu_data;
  - rf_wen = (rd != 0).
  
  With no handshake, rf_wen = 0, and rf_waddr/rf_wdata hold their previous values.
- Writes to x0: the handshake completes and instret counts it, but rf_wen stays 0.
- Scoreboard: a 32-bit busy vector.
  - ld_issue with ld_issue_rd != 0 sets busy[ld_issue_rd].
  - A load handshake clears busy[ld_rd].
  - Set and clear of the same bit in the same cycle: set wins.
  - busy[0] is always 0.
- Outstanding loads: upstream guarantees at most one outstanding load per register. A second issue to a busy register leaves the bit set.
- Hazard outputs: rs1_busy = busy[rs1] and rs2_busy = busy[rs2]. Both are combinational from the registered vector and do not see same-cycle issues.
- instret: +1 per handshake on either port, wraps modulo 2^64.

## Timing
- Reset (rst_n = 0 at a rising edge) clears:
  - rf_wen, rf_waddr, rf_wdata;
  - busy;
  - instret.
  
  While rst_n = 0, alu_ready still follows !ld_valid, and the handshakes have no effect.
- Reset mid-operation: pending busy bits are lost. Upstream must flush.
- Handshake in cycle N:
  - rf_* valid in cycle N+1;
  - register file written at the end of N+1;
  - instret updated at the edge ending cycle N.
- Busy bit set by ld_issue in cycle N: visible on rsX_busy from cycle N+1.
- Load handshake in cycle N: busy cleared from N+1, the same cycle rf_wen asserts. Decode must forward or stall one further cycle (RF read sees the new value in N+2).
- Throughput: one write per cycle. An ALU result stalls only during cycles with ld_valid = 1.

## Test plan
- Reset then idle: outputs are 0. ALU result alu_rd = 5, alu_data = 0x1234 -> alu_ready = 1; next cycle rf_wen = 1, rf_waddr = 5, rf_wdata = 0x1234; instret = 1.
- Collision: alu_valid and ld_valid in the same cycle (ld_rd = 3, lw, offset 4, ld_rdata = 0x80000001_00000000) -> alu_ready = 0.
  - Next cycle: write x3 = 0xFFFFFFFF_80000001.
  - ALU result accepted the following cycle, written one cycle later.
- Extraction sweep, ld_rdata = 0x8877665544332211:
  - lb off 7 -> 0xFFFFFFFFFFFFFF88;
  - lbu off 7 -> 0x88;
  - lh off 6 -> 0xFFFFFFFFFFFF8877;
  - lhu off 2 -> 0x4433;
  - lwu off 0 -> 0x44332211;
  - ld -> unchanged.
- Scoreboard: ld_issue rd = 10 -> rs1 = 10 gives rs1_busy = 1 next cycle. Load handshake rd = 10 -> rs1_busy = 0 the cycle after. ld_issue rd = 10 concurrent with writeback of rd = 10 -> the bit stays 1.
- x0: ALU rd = 0 and ld_issue rd = 0 -> rf_wen stays 0, rs1_busy for rs1 = 0 stays 0, instret increments.
- Reset mid-stream: assert rst_n = 0 with busy[7] set and a write pending -> next cycle busy, rf_wen and instret are all 0.

Source files
------------

// File: rtl/ysyx_22050854_wb_unit.sv
// Writeback unit: arbitrates ALU and load results, extends load data, drives the
// register-file write port one cycle later, tracks pending loads and retired count.
module ysyx_22050854_wb_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [2:0]      ld_offset,
    input  logic [XLEN-1:0] ld_rdata,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [XLEN-1:0] instret
);

    localparam int unsigned NREG = 32;

    logic            ld_hs;
    logic            alu_hs;
    logic            any_hs;
    logic [4:0]      hs_rd;
    logic [XLEN-1:0] hs_data;
    logic [XLEN-1:0] ld_ext;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     lane_w;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Load path has fixed priority; it is never back-pressured.
    assign ld_ready  = 1'b1;
    assign alu_ready = !ld_valid;
    assign ld_hs     = ld_valid;
    assign alu_hs    = alu_valid && !ld_valid;
    assign any_hs    = ld_hs || alu_hs;

    // Sub-word lanes; unused low offset bits are dropped for naturally aligned lanes.
    assign lane_b = ld_rdata[{ld_offset, 3'b000} +: 8];
    assign lane_h = ld_rdata[{ld_offset[2:1], 4'b0000} +: 16];
    assign lane_w = ld_rdata[{ld_offset[2], 5'b00000} +: 32];

    always_comb begin
        ld_ext = '0;
        case (ld_funct3)
            3'b000:  ld_ext = {{(XLEN-8){lane_b[7]}}, lane_b};
            3'b001:  ld_ext = {{(XLEN-16){lane_h[15]}}, lane_h};
            3'b010:  ld_ext = {{(XLEN-32){lane_w[31]}}, lane_w};
            3'b011:  ld_ext = ld_rdata;
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, lane_b};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, lane_h};
            3'b110:  ld_ext = {{(XLEN-32){1'b0}}, lane_w};
            default: ld_ext = '0;
        endcase
    end

    always_comb begin
        hs_rd   = alu_rd;
        hs_data = alu_data;
        if (ld_hs) begin
            hs_rd   = ld_rd;
            hs_data = ld_ext;
        end
    end

    // Scoreboard update: a same-cycle issue overrides the writeback clear.
    always_comb begin
        busy_nxt = busy;
        if (ld_hs) begin
            busy_nxt[ld_rd] = 1'b0;
        end
        if (ld_issue) begin
            busy_nxt[ld_issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy     <= '0;
            instret  <= '0;
        end else begin
            busy   <= busy_nxt;
            rf_wen <= any_hs && (hs_rd != 5'd0);
            if (any_hs) begin
                rf_waddr <= hs_rd;
                rf_wdata <= hs_data;
                instret  <= instret + XLEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050854_wb_unit.sv
// Directed self-checking bench for ysyx_22050854_wb_unit.
module tb_ysyx_22050854_wb_unit;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [2:0]  ld_offset;
    logic [63:0] ld_rdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_ir;

    ysyx_22050854_wb_unit #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
        .ld_offset(ld_offset), .ld_rdata(ld_rdata),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Extraction sweep vectors: funct3, offset, expected value.
    logic [2:0]  tv_f3  [11] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b110, 3'b011,
                                 3'b001, 3'b010, 3'b110, 3'b111, 3'b000};
    logic [2:0]  tv_off [11] = '{3'd7, 3'd7, 3'd6, 3'd2, 3'd0, 3'd5,
                                 3'd7, 3'd4, 3'd7, 3'd3, 3'd0};
    logic [63:0] tv_exp [11] = '{64'hFFFF_FFFF_FFFF_FF88, 64'h0000_0000_0000_0088,
                                 64'hFFFF_FFFF_FFFF_8877, 64'h0000_0000_0000_4433,
                                 64'h0000_0000_4433_2211, 64'h8877_6655_4433_2211,
                                 64'hFFFF_FFFF_FFFF_8877, 64'hFFFF_FFFF_8877_6655,
                                 64'h0000_0000_8877_6655, 64'h0000_0000_0000_0000,
                                 64'h0000_0000_0000_0011};

    initial begin
        rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0; ld_valid = 1'b0; ld_rd = '0;
        ld_funct3 = '0; ld_offset = '0; ld_rdata = '0; rs1 = '0; rs2 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_wen", 64'(rf_wen), 64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", rf_wdata, 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_busy", 64'(rs1_busy), 64'd0);

        // Single ALU result
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        #1;
        check("alu_ready", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        check("alu_wen", 64'(rf_wen), 64'd1);
        check("alu_waddr", 64'(rf_waddr), 64'd5);
        check("alu_wdata", rf_wdata, 64'h1234);
        check("alu_instret", instret, 64'd1);
        tick();
        check("idle_wen", 64'(rf_wen), 64'd0);
        check("idle_hold", rf_wdata, 64'h1234);

        // Collision: load wins, ALU waits a cycle
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'hABCD;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_funct3 = 3'b010; ld_offset = 3'd4;
        ld_rdata = 64'h8000_0001_0000_0000;
        #1;
        check("col_alu_ready", 64'(alu_ready), 64'd0);
        check("col_ld_ready", 64'(ld_ready), 64'd1);
        tick();
        ld_valid = 1'b0;
        check("col_ld_waddr", 64'(rf_waddr), 64'd3);
        check("col_ld_wdata", rf_wdata, 64'hFFFF_FFFF_8000_0001);
        check("col_ir2", instret, 64'd2);
        #1;
        check("col_alu_ready2", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        check("col_alu_wen", 64'(rf_wen), 64'd1);
        check("col_alu_waddr", 64'(rf_waddr), 64'd6);
        check("col_alu_wdata", rf_wdata, 64'hABCD);
        check("col_ir3", instret, 64'd3);
        exp_ir = 64'd3;

        // Extraction sweep
        ld_rdata = 64'h8877_6655_4433_2211;
        ld_rd = 5'd1;
        for (int i = 0; i < 11; i++) begin
            ld_valid = 1'b1; ld_funct3 = tv_f3[i]; ld_offset = tv_off[i];
            tick();
            ld_valid = 1'b0;
            exp_ir = exp_ir + 64'd1;
            check($sformatf("ext%0d_f%0d_o%0d", i, tv_f3[i], tv_off[i]), rf_wdata, tv_exp[i]);
        end
        check("ext_instret", instret, exp_ir);

        // Scoreboard
        ld_issue = 1'b1; ld_issue_rd = 5'd10; rs1 = 5'd10; rs2 = 5'd10;
        #1;
        check("sb_no_bypass", 64'(rs1_busy), 64'd0);
        tick();
        ld_issue = 1'b0;
        check("sb_set_rs1", 64'(rs1_busy), 64'd1);
        check("sb_set_rs2", 64'(rs2_busy), 64'd1);
        ld_valid = 1'b1; ld_rd = 5'd10; ld_funct3 = 3'b011;
        tick();
        ld_valid = 1'b0;
        exp_ir = exp_ir + 64'd1;
        check("sb_clr", 64'(rs1_busy), 64'd0);
        check("sb_clr_wen", 64'(rf_wen), 64'd1);
        check("sb_clr_waddr", 64'(rf_waddr), 64'd10);
        ld_issue = 1'b1;
        tick();
        check("sb_reset2", 64'(rs1_busy), 64'd1);
        ld_valid = 1'b1;
        tick();
        ld_issue = 1'b0; ld_valid = 1'b0;
        exp_ir = exp_ir + 64'd1;
        check("sb_set_wins", 64'(rs1_busy), 64'd1);
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        exp_ir = exp_ir + 64'd1;
        check("sb_final_clr", 64'(rs1_busy), 64'd0);

        // x0 destination
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h55;
        ld_issue = 1'b1; ld_issue_rd = 5'd0; rs1 = 5'd0;
        tick();
        alu_valid = 1'b0; ld_issue = 1'b0;
        exp_ir = exp_ir + 64'd1;
        check("x0_alu_wen", 64'(rf_wen), 64'd0);
        check("x0_busy", 64'(rs1_busy), 64'd0);
        check("x0_instret", instret, exp_ir);
        ld_valid = 1'b1; ld_rd = 5'd0;
        tick();
        ld_valid = 1'b0;
        exp_ir = exp_ir + 64'd1;
        check("x0_ld_wen", 64'(rf_wen), 64'd0);
        check("x0_ld_instret", instret, exp_ir);

        // Reset mid-stream
        ld_issue = 1'b1; ld_issue_rd = 5'd7; rs1 = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
        tick();
        ld_issue = 1'b0;
        exp_ir = exp_ir + 64'd1;
        check("mid_busy7", 64'(rs1_busy), 64'd1);
        check("mid_pending", 64'(rf_wen), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        check("mid_rst_busy", 64'(rs1_busy), 64'd0);
        check("mid_rst_wen", 64'(rf_wen), 64'd0);
        check("mid_rst_instret", instret, 64'd0);
        check("mid_rst_wdata", rf_wdata, 64'd0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
